fir_tap_sequencer: RTL and testbench

Control and accumulate stage wrapped around the FIR core's 2-cycle registered ALU (add/multiply, 16-bit operands, 32-bit result). It does four things:
- accepts input samples over a valid/ready handshake and keeps an NTAPS-deep delay line and a coefficient register file;
- issues one sample×coefficient product to the ALU per cycle;
- accumulates the returned ALU results into a wide accumulator;
- presents each filter output over a valid/ready handshake.

It drives the ALU operand/op-select inputs (upstream) and consumes the ALU result (downstream).

---
 rtl/fir_tap_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer.sv
`default_nettype none
// == fir_tap_sequencer : feeds tap products to the 2-cycle ALU, accumulates, emits y ==
// == rev 1.0 ==========================================================================
module fir_tap_sequencer #(
    parameter int NTAPS = 8,
    parameter int DW    = 16,
    parameter int ACC_W = 35,
    localparam int AW   = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_data,
    input  logic             coef_we,
    input  logic [AW-1:0]    coef_addr,
    input  logic [DW-1:0]    coef_wdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ACC_W-1:0] m_data,
    output logic [1:0]       alu_op_sel,
    output logic [DW-1:0]    alu_a,
    output logic [DW-1:0]    alu_b,
    input  logic [31:0]      alu_result
);
    localparam logic [1:0]    OP_NONE  = 2'b00;
    localparam logic [1:0]    OP_MUL   = 2'b01;
    localparam logic [AW:0]   NTAPS_W  = (AW+1)'(NTAPS);
    localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS-1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [DW-1:0]    dl_q [NTAPS];
    logic [DW-1:0]    dl_d [NTAPS];
    logic [DW-1:0]    coef_q [NTAPS];
    logic [DW-1:0]    coef_d [NTAPS];
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [1:0]       inflight_q, inflight_d;
    logic             s_ready_q, s_ready_d;
    logic             m_valid_q, m_valid_d;
    logic [ACC_W-1:0] m_data_q, m_data_d;
    logic [1:0]       op_sel_q, op_sel_d;
    logic [DW-1:0]    alu_a_q, alu_a_d;
    logic [DW-1:0]    alu_b_q, alu_b_d;
    logic             coef_wr_ok;

    assign coef_wr_ok = coef_we && (state_q == IDLE) && ({1'b0, coef_addr} < NTAPS_W);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dl_d       = dl_q;
        coef_d     = coef_q;
        acc_d      = acc_q;
        m_data_d   = m_data_q;
        inflight_d = {inflight_q[0], state_q == ISSUE};

        // Stage 1 of the in-flight register marks an ALU result that belongs to this sample
        if (inflight_q[1]) begin
            acc_d = acc_q + {{(ACC_W-32){1'b0}}, alu_result};
        end
        if (coef_wr_ok) begin
            coef_d[coef_addr] = coef_wdata;
        end

        case (state_q)
            IDLE: begin
                if (s_valid && s_ready_q) begin
                    for (int k = NTAPS-1; k > 0; k--) begin
                        dl_d[k] = dl_q[k-1];
                    end
                    dl_d[0] = s_data;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (idx_q == LAST_TAP) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            DRAIN: begin
                if (inflight_q == 2'b00) begin
                    state_d  = OUTPUT;
                    m_data_d = acc_q;
                end
            end
            OUTPUT: begin
                if (m_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr) begin
            state_d    = IDLE;
            idx_d      = '0;
            acc_d      = '0;
            inflight_d = '0;
            coef_d     = coef_q;
            for (int k = 0; k < NTAPS; k++) begin
                dl_d[k] = '0;
            end
        end

        // Outputs are registered from the next state so they line up with it
        s_ready_d = (state_d == IDLE);
        m_valid_d = (state_d == OUTPUT);
        op_sel_d  = (state_d == ISSUE || state_d == DRAIN) ? OP_MUL : OP_NONE;
        alu_a_d   = (state_d == ISSUE) ? dl_d[idx_d]   : '0;
        alu_b_d   = (state_d == ISSUE) ? coef_d[idx_d] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            acc_q      <= '0;
            inflight_q <= '0;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            op_sel_q   <= OP_NONE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            for (int k = 0; k < NTAPS; k++) begin
                dl_q[k]   <= '0;
                coef_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            inflight_q <= inflight_d;
            s_ready_q  <= s_ready_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            op_sel_q   <= op_sel_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            for (int k = 0; k < NTAPS; k++) begin
                dl_q[k]   <= dl_d[k];
                coef_q[k] <= coef_d[k];
            end
        end
    end

    assign s_ready    = s_ready_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign alu_op_sel = op_sel_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_sequencer.sv
`default_nettype none
// == tb_fir_tap_sequencer : random and directed stimulus against a sum-of-products model ==
// == rev 1.0 ==============================================================================
module tb_fir_tap_sequencer;
    localparam int NTAPS = 8;
    localparam int DW    = 16;
    localparam int ACC_W = 35;
    localparam int AW    = 3;
    localparam int LAT   = NTAPS + 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [DW-1:0]    s_data = '0;
    logic             coef_we = 1'b0;
    logic [AW-1:0]    coef_addr = '0;
    logic [DW-1:0]    coef_wdata = '0;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [ACC_W-1:0] m_data;
    logic [1:0]       alu_op_sel;
    logic [DW-1:0]    alu_a;
    logic [DW-1:0]    alu_b;
    logic [31:0]      alu_p1 = '0;
    logic [31:0]      alu_result = '0;

    int               n_checks = 0;
    int               n_errors = 0;
    longint unsigned  coef_m [NTAPS];
    longint unsigned  hist [NTAPS];

    always #5 clk = ~clk;

    fir_tap_sequencer #(.NTAPS(NTAPS), .DW(DW), .ACC_W(ACC_W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .alu_op_sel (alu_op_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result)
    );

    // Two-stage registered ALU: operands in cycle t, result visible in cycle t+2
    always @(posedge clk) begin
        alu_p1     <= (alu_op_sel == 2'b01) ? 32'(alu_a) * 32'(alu_b) : 32'(alu_a) + 32'(alu_b);
        alu_result <= alu_p1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ACC_W-1:0] model_y();
        longint unsigned s;
        s = 0;
        for (int k = 0; k < NTAPS; k++) begin
            s += coef_m[k] * hist[k];
        end
        return s[ACC_W-1:0];
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (!s_ready && n < 64) begin
            step();
            n++;
        end
        check("s_ready_idle", s_ready, 1);
    endtask

    task automatic wcoef(input int addr, input logic [DW-1:0] val);
        coef_we    = 1'b1;
        coef_addr  = AW'(addr);
        coef_wdata = val;
        step();
        coef_we    = 1'b0;
        coef_m[addr] = val;
    endtask

    task automatic push(input logic [DW-1:0] d, input int hold, input bit same_wr, input bit issue_wr);
        int               lat;
        logic [ACC_W-1:0] exp_y;
        logic [DW-1:0]    wv;
        wait_idle();
        m_ready = (hold == 0);
        s_valid = 1'b1;
        s_data  = d;
        if (same_wr) begin
            wv         = DW'($urandom);
            coef_we    = 1'b1;
            coef_addr  = AW'($urandom_range(0, NTAPS-1));
            coef_wdata = wv;
            coef_m[coef_addr] = wv;
        end
        step();
        s_valid = 1'b0;
        coef_we = 1'b0;
        for (int k = NTAPS-1; k > 0; k--) begin
            hist[k] = hist[k-1];
        end
        hist[0] = d;
        exp_y = model_y();
        lat = 0;
        do begin
            if (issue_wr && lat == 2) begin
                coef_we    = 1'b1;
                coef_addr  = AW'(2);
                coef_wdata = 16'hBEEF;
            end
            if (lat == 3) coef_we = 1'b0;
            step();
            lat++;
            if (lat == 1) check("s_ready_busy", s_ready, 0);
        end while (!m_valid && lat < 40);
        check("latency", lat, LAT);
        check("m_data", m_data, exp_y);
        for (int h = 0; h < hold; h++) begin
            step();
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, exp_y);
            check("hold_sready", s_ready, 0);
        end
        m_ready = 1'b1;
        step();
        check("m_valid_drop", m_valid, 0);
        check("s_ready_back", s_ready, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_op_sel"}, alu_op_sel, 0);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        for (int k = 0; k < NTAPS; k++) begin
            coef_m[k] = 0;
            hist[k]   = 0;
        end

        // Reset values and s_ready rising one edge after release
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        check("s_ready_at_release", s_ready, 0);
        step();
        check("s_ready_after_release", s_ready, 1);

        // Impulse response with coef = 1..8; a write during ISSUE must be dropped
        for (int k = 0; k < NTAPS; k++) wcoef(k, DW'(k + 1));
        push(16'd1, 0, 1'b0, 1'b1);
        for (int i = 0; i < NTAPS; i++) push(16'd0, 0, 1'b0, 1'b0);

        // clr during ISSUE cycle 3: no output, delay line cleared, coefficients kept
        wait_idle();
        s_valid = 1'b1;
        s_data  = 16'h1234;
        step();
        s_valid = 1'b0;
        repeat (3) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 0; k < NTAPS; k++) hist[k] = 0;
        check("clr_s_ready", s_ready, 1);
        check("clr_op_sel", alu_op_sel, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (m_valid) seen = 1'b1;
        end
        check("clr_no_m_valid", seen, 0);
        push(16'd1, 0, 1'b0, 1'b0);
        push(16'd0, 0, 1'b0, 1'b0);

        // Full-scale operands: largest sums without wrap
        for (int k = 0; k < NTAPS; k++) wcoef(k, 16'hFFFF);
        for (int i = 0; i < NTAPS; i++) push(16'hFFFF, 0, 1'b0, 1'b0);
        push(16'd0, 0, 1'b0, 1'b0);

        // Backpressure: five cycles of m_ready low in OUTPUT
        push(16'h0042, 5, 1'b0, 1'b0);

        // Random coefficients, samples, backpressure and same-cycle coefficient writes
        for (int k = 0; k < NTAPS; k++) wcoef(k, DW'($urandom));
        for (int i = 0; i < 14; i++) begin
            push(DW'($urandom), $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 1'b0);
        end

        // Reset pulsed during DRAIN: immediate zero outputs, coefficients back to zero
        wait_idle();
        s_valid = 1'b1;
        s_data  = 16'h0007;
        step();
        s_valid = 1'b0;
        repeat (9) step();
        check("drain_op_sel", alu_op_sel, 2'b01);
        rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_s_ready_release", s_ready, 0);
        step();
        check("midrst_s_ready_up", s_ready, 1);
        for (int k = 0; k < NTAPS; k++) begin
            coef_m[k] = 0;
            hist[k]   = 0;
        end
        push(16'd1, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
